mem_access_stage: RTL

MEM-stage engine of the 16-bit pipelined CPU. It consumes the EX/MEM pipeline fields (WB, MEM, FU_result, RT_data, Write_dst) and performs the data-memory read or write over a req/ack handshake. While an access is outstanding it stalls the upstream pipeline, and it registers the results into the MEM/WB fields for the write-back stage.

---
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 16-bit pipelined CPU.
// Performs one data-memory read or write per memory instruction over a
// req/ack handshake, stalls upstream while the access is outstanding, and
// registers the MEM/WB fields for write-back.
//
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT cycles).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   WB_i, MEM_i           EX/MEM control (RegWrite/MemtoReg, MemRead/MemWrite)
//   FU_result_i           ALU result / memory address
//   RT_data_i             store data
//   Write_dst_i           destination register
//   stall_o               combinational upstream hold
//   dmem_*                registered memory request channel, ack/rdata inputs
//   WB_o, Read_data_o,
//   FU_result_o,
//   Write_dst_o           registered MEM/WB fields
//   err_o                 sticky error (illegal MEM_i, timeout abort)
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        MEM_i,
  input  logic [15:0]       FU_result_i,
  input  logic [15:0]       RT_data_i,
  input  logic [2:0]        Write_dst_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [15:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [15:0]       dmem_rdata_i,
  output logic [1:0]        WB_o,
  output logic [15:0]       Read_data_o,
  output logic [15:0]       FU_result_o,
  output logic [2:0]        Write_dst_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Command captured at detect time, replayed into MEM/WB on ack
  typedef struct packed {
    logic [1:0]  wb;
    logic [15:0] fu;
    logic [2:0]  dst;
    logic        we;
  } cmd_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, rd_q, rd_d, fu_q, fu_d;
  logic [1:0]        wb_q, wb_d;
  logic [2:0]        dst_q, dst_d;
  logic              stall_c, access_c, timeout_c;

  assign access_c  = MEM_i[1] | MEM_i[0];
  assign timeout_c = TMO_EN && (cnt_q == CNT_W'(TIMEOUT));

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
      fu_q    <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      fu_q    <= fu_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; MEM/WB defaults to a bubble
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wb_d    = '0;
    rd_d    = '0;
    fu_d    = '0;
    dst_d   = '0;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          stall_c   = 1'b1;
          cmd_d.wb  = WB_i;
          cmd_d.fu  = FU_result_i;
          cmd_d.dst = Write_dst_i;
          cmd_d.we  = MEM_i[0];
          req_d     = 1'b1;
          we_d      = MEM_i[0];
          addr_d    = FU_result_i[ADDR_W-1:0];
          wdata_d   = RT_data_i;
          cnt_d     = '0;
          // MemRead and MemWrite together: do the write, flag the error
          if (MEM_i == 2'b11) err_d = 1'b1;
          state_d   = S_WAIT;
        end else begin
          wb_d  = WB_i;
          fu_d  = FU_result_i;
          dst_d = Write_dst_i;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          wb_d    = cmd_q.wb;
          fu_d    = cmd_q.fu;
          dst_d   = cmd_q.dst;
          rd_d    = cmd_q.we ? 16'h0000 : dmem_rdata_i;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (timeout_c) begin
          // Abort: release the pipeline without a register write
          rd_d    = 16'hDEAD;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces every output low, including the combinational stall
  assign stall_o      = stall_c & ~rst_i;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign WB_o         = wb_q;
  assign Read_data_o  = rd_q;
  assign FU_result_o  = fu_q;
  assign Write_dst_o  = dst_q;
  assign err_o        = err_q;

endmodule
